// File: rtl/spi_init_sequencer_if.sv
// spi_init_sequencer_if: control, ROM, host and SPI-master signals of the init sequencer
interface spi_init_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int DEV_W  = 2,
  parameter int ADDR_W = 6
);
  logic                    init_start;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DEV_W+WIDTH-1:0]  rom_data;
  logic                    host_req;
  logic [DEV_W-1:0]        host_dev;
  logic [WIDTH-1:0]        host_wdata;
  logic                    host_ack;
  logic [WIDTH-1:0]        host_rdata;
  logic                    start_tx;
  logic [WIDTH-1:0]        tx_data;
  logic [DEV_W-1:0]        spi_dev;
  logic                    done_tx;
  logic [WIDTH-1:0]        rx_data;
  logic                    busy;
  logic                    init_done;
  logic                    init_err;
  modport master (
    input  init_start, rom_data, host_req, host_dev, host_wdata, done_tx, rx_data,
    output rom_addr, host_ack, host_rdata, start_tx, tx_data, spi_dev, busy, init_done, init_err
  );
  modport slave (
    output init_start, rom_data, host_req, host_dev, host_wdata, done_tx, rx_data,
    input  rom_addr, host_ack, host_rdata, start_tx, tx_data, spi_dev, busy, init_done, init_err
  );
endinterface

// File: rtl/spi_init_sequencer.sv
// spi_init_sequencer: walks a registered config ROM into the SPI master, then serves host transactions
module spi_init_sequencer #(
  parameter int WIDTH      = 32,
  parameter int DEV_W      = 2,
  parameter int ADDR_W     = 6,
  parameter int N_ENTRIES  = 16,
  parameter int GAP_CYCLES = 15,
  parameter int TIMEOUT    = 4095
) (
  input logic                  clk,
  input logic                  rst,
  spi_init_sequencer_if.master bus
);
  localparam int CNT_MAX  = TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int GAP_LAST = GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, GAP, ERR} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [DEV_W-1:0]  spi_dev_q, spi_dev_d;
  logic [WIDTH-1:0]  host_rdata_q, host_rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              start_tx_q, start_tx_d;
  logic              host_ack_q, host_ack_d;
  logic              host_mode_q, host_mode_d;
  logic              init_done_q, init_done_d;
  logic              init_err_q, init_err_d;
  logic              busy_q, busy_d;
  always_comb begin
    state_d      = state_q;
    rom_addr_d   = rom_addr_q;
    tx_data_d    = tx_data_q;
    spi_dev_d    = spi_dev_q;
    host_rdata_d = host_rdata_q;
    cnt_d        = cnt_q;
    start_tx_d   = 1'b0;
    host_ack_d   = 1'b0;
    host_mode_d  = host_mode_q;
    init_done_d  = init_done_q;
    init_err_d   = init_err_q;
    case (state_q)
      IDLE, ERR: begin
        if (bus.init_start) begin
          rom_addr_d  = '0;
          init_done_d = 1'b0;
          init_err_d  = 1'b0;
          host_mode_d = 1'b0;
          state_d     = FETCH;
        end else if (state_q == IDLE && bus.host_req && init_done_q && !host_ack_q) begin
          // the previous-cycle ack guard keeps a request still high from the last ack from re-issuing
          tx_data_d   = bus.host_wdata;
          spi_dev_d   = bus.host_dev;
          start_tx_d  = 1'b1;
          host_mode_d = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        tx_data_d  = bus.rom_data[WIDTH-1:0];
        spi_dev_d  = bus.rom_data[WIDTH +: DEV_W];
        start_tx_d = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (bus.done_tx) begin
          cnt_d = '0;
          if (host_mode_q) begin
            host_rdata_d = bus.rx_data;
            host_ack_d   = 1'b1;
            host_mode_d  = 1'b0;
            state_d      = IDLE;
          end else if (rom_addr_q == ADDR_W'(N_ENTRIES - 1)) begin
            init_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = GAP_CYCLES > 0 ? GAP : FETCH;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          init_err_d = 1'b1;
          state_d    = ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = cnt_q == CNT_W'(GAP_LAST) ? FETCH : GAP;
        cnt_d   = cnt_q == CNT_W'(GAP_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rom_addr_q   <= '0;
      tx_data_q    <= '0;
      spi_dev_q    <= '0;
      host_rdata_q <= '0;
      cnt_q        <= '0;
      start_tx_q   <= 1'b0;
      host_ack_q   <= 1'b0;
      host_mode_q  <= 1'b0;
      init_done_q  <= 1'b0;
      init_err_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      tx_data_q    <= tx_data_d;
      spi_dev_q    <= spi_dev_d;
      host_rdata_q <= host_rdata_d;
      cnt_q        <= cnt_d;
      start_tx_q   <= start_tx_d;
      host_ack_q   <= host_ack_d;
      host_mode_q  <= host_mode_d;
      init_done_q  <= init_done_d;
      init_err_q   <= init_err_d;
      busy_q       <= busy_d;
    end
  end
  assign bus.rom_addr   = rom_addr_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.spi_dev    = spi_dev_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.start_tx   = start_tx_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.init_done  = init_done_q;
  assign bus.init_err   = init_err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_spi_init_sequencer.sv
// tb_spi_init_sequencer: scoreboarded scenarios around a 3-entry ROM and a 10-cycle SPI master model
module tb_spi_init_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_init_sequencer_if #(.WIDTH(32), .DEV_W(2), .ADDR_W(6)) bus();
  spi_init_sequencer #(.WIDTH(32), .DEV_W(2), .ADDR_W(6), .N_ENTRIES(3), .GAP_CYCLES(2), .TIMEOUT(100))
    dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic [31:0] c; logic [1:0] dev; logic [31:0] d;} ev_t;
  ev_t  start_q[$], ack_q[$], exp_s[$], exp_a[$];
  int   done_q[$], err_q[$];
  int   cyc = 0, n_cmp = 0, n_err = 0;
  logic hang_en = 1'b0;
  logic [31:0] hang_tx = '0;
  logic [3:0]  spi_cnt = '0;
  logic [31:0] spi_tx = '0;
  logic done_p = 1'b0, err_p = 1'b0;
  function automatic logic [33:0] rom_word(input logic [5:0] a);
    return a == 6'd0 ? {2'd1, 32'h11} : a == 6'd1 ? {2'd2, 32'h22} : a == 6'd2 ? {2'd3, 32'h33} : '0;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);
  // done_tx rises 10 cycles after start_tx, returning the inverted frame
  always @(posedge clk) begin
    bus.done_tx <= 1'b0;
    if (bus.start_tx && !(hang_en && bus.tx_data == hang_tx)) begin
      spi_cnt <= 4'd9;
      spi_tx  <= bus.tx_data;
    end else if (spi_cnt == 4'd1) begin
      bus.done_tx <= 1'b1;
      bus.rx_data <= ~spi_tx;
      spi_cnt     <= '0;
    end else if (spi_cnt != '0) begin
      spi_cnt <= spi_cnt - 4'd1;
    end
  end
  always @(negedge clk) begin
    if (bus.start_tx) start_q.push_back({32'(cyc), bus.spi_dev, bus.tx_data});
    if (bus.host_ack) ack_q.push_back({32'(cyc), 2'd0, bus.host_rdata});
    if (bus.init_done && !done_p) done_q.push_back(cyc);
    if (bus.init_err && !err_p) err_q.push_back(cyc);
    done_p <= bus.init_done;
    err_p  <= bus.init_err;
  end
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.host_ack) bus.host_req = 1'b0;
    end
  endtask
  task automatic start_init(output int acc);
    @(negedge clk);
    bus.init_start = 1'b1;
    acc = cyc;
    @(negedge clk);
    bus.init_start = 1'b0;
  endtask
  task automatic clear_q();
    start_q.delete(); ack_q.delete(); done_q.delete(); err_q.delete(); exp_s.delete(); exp_a.delete();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.init_start = 1'b0; bus.host_req = 1'b0; bus.host_dev = '0; bus.host_wdata = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.rom_addr, bus.start_tx, bus.tx_data, bus.spi_dev} !== '0) begin
      n_err++; $display("FAIL reset_tx: got %h want 0", {bus.rom_addr, bus.start_tx, bus.tx_data, bus.spi_dev});
    end
    n_cmp++;
    if ({bus.host_ack, bus.host_rdata} !== '0) begin
      n_err++; $display("FAIL reset_host: got %h want 0", {bus.host_ack, bus.host_rdata});
    end
    n_cmp++;
    if ({bus.busy, bus.init_done, bus.init_err} !== 3'b000) begin
      n_err++; $display("FAIL reset_status: got %b want 000", {bus.busy, bus.init_done, bus.init_err});
    end
    rst = 1'b0;
  endtask
  task automatic test_host_before_init();
    clear_q();
    bus.host_req = 1'b1; bus.host_dev = 2'd1; bus.host_wdata = 32'h12345678;
    run(20);
    n_cmp++;
    if (start_q.size() != 0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL pre_init_host: got starts=%0d busy=%b want 0 0", start_q.size(), bus.busy);
    end
    bus.host_req = 1'b0;
    run(2);
  endtask
  task automatic test_basic_sequence();
    int acc, v;
    ev_t got, want;
    clear_q();
    start_init(acc);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
    exp_s.push_back({32'(acc + 3), 2'd1, 32'h11});
    exp_s.push_back({32'(acc + 18), 2'd2, 32'h22});
    exp_s.push_back({32'(acc + 33), 2'd3, 32'h33});
    run(50);
    while (exp_s.size() != 0) begin
      want = exp_s.pop_front();
      got = '0;
      if (start_q.size() != 0) got = start_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL basic_start: got c=%0d dev=%0d tx=%h want c=%0d dev=%0d tx=%h", got.c, got.dev, got.d, want.c, want.dev, want.d);
      end
    end
    v = done_q.size() != 0 ? done_q[0] : -1;
    n_cmp++;
    if (v != acc + 44) begin n_err++; $display("FAIL basic_done_cycle: got %0d want %0d", v, acc + 44); end
    n_cmp++;
    if ({bus.busy, bus.init_done, bus.init_err, bus.rom_addr} !== {3'b010, 6'd2}) begin
      n_err++; $display("FAIL basic_final: got %b want 010000010", {bus.busy, bus.init_done, bus.init_err, bus.rom_addr});
    end
  endtask
  task automatic test_host();
    int acc;
    ev_t got, want;
    clear_q();
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_dev = 2'd2; bus.host_wdata = 32'hA5A5A5A5;
    acc = cyc;
    exp_s.push_back({32'(acc + 1), 2'd2, 32'hA5A5A5A5});
    exp_a.push_back({32'(acc + 12), 2'd0, 32'h5A5A5A5A});
    run(25);
    want = exp_s.pop_front(); got = '0;
    if (start_q.size() != 0) got = start_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL host_start: got c=%0d dev=%0d tx=%h want c=%0d dev=%0d tx=%h", got.c, got.dev, got.d, want.c, want.dev, want.d);
    end
    want = exp_a.pop_front(); got = '0;
    if (ack_q.size() != 0) got = ack_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL host_ack: got c=%0d rdata=%h want c=%0d rdata=%h", got.c, got.d, want.c, want.d);
    end
    n_cmp++;
    if (start_q.size() != 0 || ack_q.size() != 0 || bus.host_rdata !== 32'h5A5A5A5A) begin
      n_err++; $display("FAIL host_single: got starts=%0d acks=%0d rdata=%h want 0 0 5a5a5a5a", start_q.size(), ack_q.size(), bus.host_rdata);
    end
  endtask
  task automatic test_host_during_init(input int delay, input string tag);
    int acc, v;
    ev_t got, want;
    clear_q();
    @(negedge clk);
    bus.init_start = 1'b1;
    bus.host_dev = 2'd1; bus.host_wdata = 32'h0000BEEF;
    if (delay == 0) bus.host_req = 1'b1;
    acc = cyc;
    @(negedge clk);
    bus.init_start = 1'b0;
    if (delay > 0) begin
      run(delay - 1);
      bus.host_req = 1'b1;
    end
    exp_s.push_back({32'(acc + 3), 2'd1, 32'h11});
    exp_s.push_back({32'(acc + 18), 2'd2, 32'h22});
    exp_s.push_back({32'(acc + 33), 2'd3, 32'h33});
    exp_s.push_back({32'(acc + 45), 2'd1, 32'h0000BEEF});
    exp_a.push_back({32'(acc + 56), 2'd0, 32'hFFFF4110});
    run(70 - delay);
    while (exp_s.size() != 0) begin
      want = exp_s.pop_front(); got = '0;
      if (start_q.size() != 0) got = start_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL %s_start: got c=%0d dev=%0d tx=%h want c=%0d dev=%0d tx=%h", tag, got.c, got.dev, got.d, want.c, want.dev, want.d);
      end
    end
    want = exp_a.pop_front(); got = '0;
    if (ack_q.size() != 0) got = ack_q.pop_front();
    n_cmp++;
    if (got !== want || ack_q.size() != 0 || start_q.size() != 0) begin
      n_err++; $display("FAIL %s_ack: got c=%0d rdata=%h extra=%0d want c=%0d rdata=%h extra=0", tag, got.c, got.d, ack_q.size() + start_q.size(), want.c, want.d);
    end
    v = done_q.size() != 0 ? done_q[0] : -1;
    n_cmp++;
    if (v != acc + 44) begin n_err++; $display("FAIL %s_done_cycle: got %0d want %0d", tag, v, acc + 44); end
  endtask
  task automatic test_timeout();
    int acc, v;
    ev_t got, want;
    clear_q();
    hang_en = 1'b1; hang_tx = 32'h22;
    start_init(acc);
    exp_s.push_back({32'(acc + 3), 2'd1, 32'h11});
    exp_s.push_back({32'(acc + 18), 2'd2, 32'h22});
    run(130);
    while (exp_s.size() != 0) begin
      want = exp_s.pop_front(); got = '0;
      if (start_q.size() != 0) got = start_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL timeout_start: got c=%0d dev=%0d tx=%h want c=%0d dev=%0d tx=%h", got.c, got.dev, got.d, want.c, want.dev, want.d);
      end
    end
    v = err_q.size() != 0 ? err_q[0] : -1;
    n_cmp++;
    if (v != acc + 118) begin n_err++; $display("FAIL timeout_err_cycle: got %0d want %0d", v, acc + 118); end
    n_cmp++;
    if ({bus.busy, bus.init_done, bus.init_err} !== 3'b101) begin
      n_err++; $display("FAIL timeout_status: got %b want 101", {bus.busy, bus.init_done, bus.init_err});
    end
    bus.host_req = 1'b1; bus.host_dev = 2'd3; bus.host_wdata = 32'hCAFE0000;
    run(10);
    n_cmp++;
    if (start_q.size() != 0 || ack_q.size() != 0 || bus.busy !== 1'b1) begin
      n_err++; $display("FAIL err_holds: got starts=%0d acks=%0d busy=%b want 0 0 1", start_q.size(), ack_q.size(), bus.busy);
    end
    bus.host_req = 1'b0;
    hang_en = 1'b0;
    clear_q();
    start_init(acc);
    n_cmp++;
    if ({bus.busy, bus.init_err} !== 2'b10) begin
      n_err++; $display("FAIL restart_clear: got busy,err=%b want 10", {bus.busy, bus.init_err});
    end
    exp_s.push_back({32'(acc + 3), 2'd1, 32'h11});
    exp_s.push_back({32'(acc + 18), 2'd2, 32'h22});
    exp_s.push_back({32'(acc + 33), 2'd3, 32'h33});
    run(50);
    while (exp_s.size() != 0) begin
      want = exp_s.pop_front(); got = '0;
      if (start_q.size() != 0) got = start_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL restart_start: got c=%0d dev=%0d tx=%h want c=%0d dev=%0d tx=%h", got.c, got.dev, got.d, want.c, want.dev, want.d);
      end
    end
    v = done_q.size() != 0 ? done_q[0] : -1;
    n_cmp++;
    if (v != acc + 44 || bus.init_err !== 1'b0) begin
      n_err++; $display("FAIL restart_done: got cycle=%0d err=%b want %0d 0", v, bus.init_err, acc + 44);
    end
  endtask
  task automatic test_reset_mid();
    int acc;
    ev_t got, want;
    clear_q();
    start_init(acc);
    run(20);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.rom_addr, bus.start_tx, bus.tx_data, bus.spi_dev, bus.host_ack, bus.host_rdata, bus.busy, bus.init_done, bus.init_err} !== '0) begin
      n_err++; $display("FAIL reset_mid_outputs: got addr=%0d tx=%h dev=%0d busy=%b done=%b err=%b want all 0", bus.rom_addr, bus.tx_data, bus.spi_dev, bus.busy, bus.init_done, bus.init_err);
    end
    rst = 1'b0;
    exp_s.push_back({32'(acc + 3), 2'd1, 32'h11});
    exp_s.push_back({32'(acc + 18), 2'd2, 32'h22});
    while (exp_s.size() != 0) begin
      want = exp_s.pop_front(); got = '0;
      if (start_q.size() != 0) got = start_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL reset_mid_start: got c=%0d dev=%0d tx=%h want c=%0d dev=%0d tx=%h", got.c, got.dev, got.d, want.c, want.dev, want.d);
      end
    end
    run(30);
    n_cmp++;
    if (start_q.size() != 0 || ack_q.size() != 0 || {bus.busy, bus.init_done, bus.rom_addr} !== '0) begin
      n_err++; $display("FAIL reset_mid_ignore_done: got starts=%0d acks=%0d busy=%b done=%b addr=%0d want 0 0 0 0 0", start_q.size(), ack_q.size(), bus.busy, bus.init_done, bus.rom_addr);
    end
  endtask
  initial begin
    test_reset();
    test_host_before_init();
    test_basic_sequence();
    test_host();
    test_host_during_init(20, "held_off");
    test_timeout();
    test_reset_mid();
    test_host_during_init(0, "simultaneous");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spi_init_sequencer.md
Name: spi_init_sequencer

Overview:
- Command source that sits directly upstream of the SPI master on the FMC151 card path.
- After power-up, walks a registered configuration ROM of SPI frames and issues each frame to the SPI master.
- Each frame goes to the selected on-card device (clock chip, ADC, DAC, monitor) and is issued through the start_tx/tx_data/done_tx/rx_data handshake.
- Once the sequence completes, arbitrates single host-issued transactions (register reads/writes from the control bus) onto the same SPI master.

Parameters:
- WIDTH, 32, SPI frame width; must match the SPI master.
- DEV_W, 2, device-select field width.
- ADDR_W, 6, ROM address width.
- N_ENTRIES, 16, number of ROM entries in the init sequence; 1..2^ADDR_W.
- GAP_CYCLES, 15, idle clk cycles between consecutive ROM frames; 0 allowed.
- TIMEOUT, 4095, max clk cycles waiting for done_tx before error; ≥1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- init_start, in, 1: pulse; start/restart the ROM sequence.
- rom_addr, out, ADDR_W: ROM address (registered).
- rom_data, in, DEV_W+WIDTH: ROM word; [WIDTH+DEV_W-1:WIDTH]=device, [WIDTH-1:0]=frame; 1-cycle registered-ROM latency.
- host_req, in, 1: host transaction request; held high until host_ack.
- host_dev, in, DEV_W: host target device; stable while host_req is high.
- host_wdata, in, WIDTH: host frame; stable while host_req is high.
- host_ack, out, 1: one-cycle pulse; host transaction complete.
- host_rdata, out, WIDTH: rx_data of the host transaction; valid from host_ack until the next host_ack.
- start_tx, out, 1: to the SPI master; one-cycle pulse.
- tx_data, out, WIDTH: to the SPI master; frame to send.
- spi_dev, out, DEV_W: device select for the chip-select decoder; held for the whole transaction.
- done_tx, in, 1: from the SPI master; one-cycle completion pulse.
- rx_data, in, WIDTH: from the SPI master; valid when done_tx is high.
- busy, out, 1: high in any state other than IDLE.
- init_done, out, 1: sticky; all N_ENTRIES frames completed.
- init_err, out, 1: sticky; a done_tx timeout occurred.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0. Reset mid-transaction aborts immediately, with no host_ack and no start_tx.
- States: IDLE, FETCH, LOAD, WAIT, GAP, ERR.
- IDLE arbitration:
  - init_start has priority over host_req.
  - init_start → rom_addr<=0, init_done<=0, init_err<=0, go to FETCH.
  - host_req (no init_start) is accepted only when init_done=1 and host_ack was not asserted in the previous cycle. On accept: tx_data<=host_wdata, spi_dev<=host_dev, start_tx<=1, host-mode flag set, go to WAIT.
- FETCH: 1 cycle; the ROM registers the word at rom_addr; go to LOAD.
- LOAD: latch tx_data<=rom_data[WIDTH-1:0] and spi_dev<=device field; start_tx<=1; go to WAIT.
- Start latency: start_tx is high in exactly one cycle, beginning 3 cycles after the edge that accepted init_start (1 cycle after accept for host requests).
- tx_data and spi_dev stay stable from start_tx until done_tx; start_tx is never pulsed while a transaction is outstanding.
- WAIT: the timeout counter clears on entry and increments each cycle.
  - done_tx in host mode: host_rdata<=rx_data, host_ack pulse, clear host-mode flag, go to IDLE.
  - done_tx in ROM mode with rom_addr==N_ENTRIES-1: init_done<=1, go to IDLE.
  - done_tx in ROM mode otherwise: rom_addr<=rom_addr+1. Go to GAP if GAP_CYCLES>0, else go to FETCH.
  - Counter reaches TIMEOUT with no done_tx: init_err<=1, go to ERR. If done_tx and the timeout occur in the same cycle, done_tx wins.
- GAP: count GAP_CYCLES cycles, then go to FETCH. Frame-to-frame start_tx spacing = SPI transaction time + GAP_CYCLES + 3.
- ERR: busy=1. Host requests are ignored. Leaves only on init_start (restart from entry 0) or rst.
- init_start outside IDLE/ERR is ignored.
- host_req while the sequence is running or init_done=0 is held off; no ack, no error.
- done_tx outside WAIT is ignored.
- rom_addr does not wrap; its maximum value is N_ENTRIES-1.

Test Plan:
- Setup: N_ENTRIES=3, GAP_CYCLES=2, TIMEOUT=100. ROM = {dev1,0x00000011}, {dev2,0x00000022}, {dev3,0x00000033}. SPI model returns done_tx 10 cycles after start_tx with rx=~tx.
- Basic sequence: init_start pulse → 3 start_tx pulses with tx_data 0x11/0x22/0x33 and spi_dev 1/2/3. First start_tx is 3 cycles after accept; spacing between starts is 10+2+3 cycles. init_done=1 one cycle after the third done_tx; busy then falls.
- Host transaction: after init_done, host_req with dev=2, wdata=0xA5A5A5A5 → start_tx 1 cycle after accept; host_ack after done_tx with host_rdata=0x5A5A5A5A; host_ack is a single cycle.
- Held-off host request: host_req asserted during the sequence → held, no start_tx for the host until init_done=1; then served once.
- Timeout: SPI model never returns done_tx on entry 1 → init_err=1 exactly 100 cycles after entering WAIT; ERR state holds. A subsequent init_start clears init_err and reruns all 3 entries.
- Reset and simultaneous events: rst in WAIT of entry 1 → all outputs 0 next cycle, and a later done_tx is ignored. init_start and host_req together in IDLE → ROM sequence runs first, host is served after.
